// File: rtl/hex_scan_display.sv
// Multiplexed seven-segment hex display scanner with blanking, masking,
// leading-zero suppression and frame-synchronous value update.
module hex_scan_display #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic                    Load,
  input  logic [NUM_DIGITS-1:0]   Blank_Mask,
  input  logic                    Lz_Suppress,
  output logic [6:0]              Seg,
  output logic [NUM_DIGITS-1:0]   Dig_Sel,
  output logic                    Frame_Done
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam bit AL = (ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF = AL ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = AL ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [VW-1:0]         active_q, active_d;
  logic                  frame_done_q, frame_done_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  logic                  tick, wrap;
  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] sel, lz;
  logic                  idx_ok, masked, suppressed, dark, zero_run;
  logic [6:0]            seg_hi;
  logic [NUM_DIGITS-1:0] dig_hi;

  // Active-low segment pattern for one hex nibble, bit 6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // Slot prescaler, digit index and double-buffered value update at frame wrap.
  always_comb begin
    tick         = (presc_q == PRESC_MAX);
    wrap         = tick && (idx_q >= IDX_MAX);
    presc_d      = tick ? '0 : presc_q + PW'(1);
    idx_d        = idx_q;
    frame_done_d = wrap;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    active_d     = active_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end
    if (wrap) begin
      if (Load) begin
        active_d   = Value;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        active_d   = pend_q;
        pend_vld_d = 1'b0;
      end
    end else if (Load) begin
      pend_d     = Value;
      pend_vld_d = 1'b1;
    end
  end

  // Next segment/enable pattern for the digit currently in its slot.
  always_comb begin
    nib        = 4'h0;
    sel        = '0;
    idx_ok     = 1'b0;
    masked     = 1'b0;
    suppressed = 1'b0;
    lz         = '0;
    zero_run   = 1'b1;
    // lz[i]: nibble i and every nibble above it are zero
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (active_q[4*i +: 4] == 4'h0);
      lz[i]    = zero_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib        = active_q[4*i +: 4];
        sel[i]     = 1'b1;
        idx_ok     = 1'b1;
        masked     = Blank_Mask[i];
        suppressed = (i != 0) && lz[i];
      end
    end
    dark   = !idx_ok || masked || (Lz_Suppress && suppressed) || (presc_q < BLANK_END);
    seg_hi = dark ? 7'h00 : ~hex_to_seg(nib);
    dig_hi = dark ? '0 : sel;
    seg_d  = AL ? ~seg_hi : seg_hi;
    dig_d  = AL ? ~dig_hi : dig_hi;
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      active_q     <= '0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      active_q     <= active_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
    end
  end

  assign Seg        = seg_q;
  assign Dig_Sel    = dig_q;
  assign Frame_Done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed testbench for hex_scan_display (4 digits, 4-cycle slots, 1 blank cycle).
module tb_hex_scan_display;

  logic        clk = 1'b0;
  logic        Reset;
  logic [15:0] Value;
  logic        Load;
  logic [3:0]  Blank_Mask;
  logic        Lz_Suppress;
  logic [6:0]  seg_al, seg_ah;
  logic [3:0]  dig_al, dig_ah;
  logic        fd_al, fd_ah;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  hex_scan_display #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1)
  ) u_dut_al (
    .Clk(clk), .Reset(Reset), .Value(Value), .Load(Load),
    .Blank_Mask(Blank_Mask), .Lz_Suppress(Lz_Suppress),
    .Seg(seg_al), .Dig_Sel(dig_al), .Frame_Done(fd_al)
  );

  hex_scan_display #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(0)
  ) u_dut_ah (
    .Clk(clk), .Reset(Reset), .Value(Value), .Load(Load),
    .Blank_Mask(Blank_Mask), .Lz_Suppress(Lz_Suppress),
    .Seg(seg_ah), .Dig_Sel(dig_ah), .Frame_Done(fd_ah)
  );

  // One rising edge, then land on the following falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic test_reset();
    Reset = 1'b1; Load = 1'b0; Value = '0; Blank_Mask = '0; Lz_Suppress = 1'b0;
    repeat (2) @(negedge clk);
    Reset = 1'b0; cyc = 0;
    repeat (6) step();
    #2 Reset = 1'b1;
    #1;
    vectors++; if (seg_al !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h expected 7f", seg_al); end
    vectors++; if (dig_al !== 4'hF)  begin errors++; $display("FAIL reset_dig: got %h expected f", dig_al); end
    vectors++; if (fd_al !== 1'b0)   begin errors++; $display("FAIL reset_fd: got %b expected 0", fd_al); end
    vectors++; if (seg_ah !== 7'h00) begin errors++; $display("FAIL reset_seg_ah: got %h expected 00", seg_ah); end
    vectors++; if (dig_ah !== 4'h0)  begin errors++; $display("FAIL reset_dig_ah: got %h expected 0", dig_ah); end
    @(negedge clk);
    Reset = 1'b0; cyc = 0;
    step();
    vectors++; if (seg_al !== 7'h7F || dig_al !== 4'hF) begin
      errors++; $display("FAIL post_reset_blank: got seg=%h dig=%h expected seg=7f dig=f", seg_al, dig_al);
    end
    step();
    vectors++; if (seg_al !== 7'h40 || dig_al !== 4'hE) begin
      errors++; $display("FAIL post_reset_d0: got seg=%h dig=%h expected seg=40 dig=e", seg_al, dig_al);
    end
    vectors++; if (seg_ah !== 7'h3F || dig_ah !== 4'h1) begin
      errors++; $display("FAIL post_reset_d0_ah: got seg=%h dig=%h expected seg=3f dig=1", seg_ah, dig_ah);
    end
  endtask

  task automatic test_scan();
    logic [6:0] es [4];
    logic [3:0] ed [4];
    logic [6:0] xs;
    logic [3:0] xd;
    logic       xf;
    es = '{7'h0E, 7'h08, 7'h24, 7'h79};
    ed = '{4'hE, 4'hD, 4'hB, 4'h7};
    wait_to(15);
    Load = 1'b1; Value = 16'h12AF;
    step();
    Load = 1'b0;
    vectors++; if (fd_al !== 1'b1) begin errors++; $display("FAIL scan_fd16: got %b expected 1", fd_al); end
    for (int t = 0; t < 16; t++) begin
      step();
      xs = ((t % 4) == 0) ? 7'h7F : es[t/4];
      xd = ((t % 4) == 0) ? 4'hF  : ed[t/4];
      xf = (cyc == 32);
      vectors++; if (seg_al !== xs) begin errors++; $display("FAIL scan_seg cyc%0d: got %h expected %h", cyc, seg_al, xs); end
      vectors++; if (dig_al !== xd) begin errors++; $display("FAIL scan_dig cyc%0d: got %h expected %h", cyc, dig_al, xd); end
      vectors++; if (fd_al !== xf)  begin errors++; $display("FAIL scan_fd cyc%0d: got %b expected %b", cyc, fd_al, xf); end
    end
  endtask

  task automatic test_tearing();
    logic [6:0] es_old [4];
    logic [6:0] es_new [4];
    logic [3:0] ed [4];
    logic [6:0] xs;
    logic [3:0] xd;
    es_old = '{7'h0E, 7'h08, 7'h24, 7'h79};
    es_new = '{7'h00, 7'h78, 7'h02, 7'h12};
    ed     = '{4'hE, 4'hD, 4'hB, 4'h7};
    wait_to(34);
    Load = 1'b1; Value = 16'h1234;
    step();
    Value = 16'h5678;
    step();
    Load = 1'b0;
    for (int t = 4; t < 16; t++) begin
      step();
      xs = ((t % 4) == 0) ? 7'h7F : es_old[t/4];
      xd = ((t % 4) == 0) ? 4'hF  : ed[t/4];
      vectors++; if (seg_al !== xs || dig_al !== xd) begin
        errors++; $display("FAIL tear_hold cyc%0d: got seg=%h dig=%h expected seg=%h dig=%h", cyc, seg_al, dig_al, xs, xd);
      end
    end
    vectors++; if (fd_al !== 1'b1) begin errors++; $display("FAIL tear_fd48: got %b expected 1", fd_al); end
    for (int t = 0; t < 15; t++) begin
      step();
      xs = ((t % 4) == 0) ? 7'h7F : es_new[t/4];
      xd = ((t % 4) == 0) ? 4'hF  : ed[t/4];
      vectors++; if (seg_al !== xs || dig_al !== xd) begin
        errors++; $display("FAIL tear_new cyc%0d: got seg=%h dig=%h expected seg=%h dig=%h", cyc, seg_al, dig_al, xs, xd);
      end
    end
  endtask

  task automatic test_suppress();
    logic [6:0] es5 [4];
    logic [3:0] ed5 [4];
    logic [6:0] es6 [4];
    logic [3:0] ed6 [4];
    logic [6:0] xs;
    logic [3:0] xd;
    es5 = '{7'h40, 7'h78, 7'h7F, 7'h7F};
    ed5 = '{4'hE, 4'hD, 4'hF, 4'hF};
    es6 = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    ed6 = '{4'hE, 4'hF, 4'hF, 4'hF};
    wait_to(63);
    Load = 1'b1; Value = 16'h0070; Lz_Suppress = 1'b1;
    step();
    Load = 1'b0;
    vectors++; if (seg_al !== 7'h12 || dig_al !== 4'h7) begin
      errors++; $display("FAIL wrap_load_last: got seg=%h dig=%h expected seg=12 dig=7", seg_al, dig_al);
    end
    for (int t = 0; t < 15; t++) begin
      step();
      xs = ((t % 4) == 0) ? 7'h7F : es5[t/4];
      xd = ((t % 4) == 0) ? 4'hF  : ed5[t/4];
      vectors++; if (seg_al !== xs || dig_al !== xd) begin
        errors++; $display("FAIL lz_0070 cyc%0d: got seg=%h dig=%h expected seg=%h dig=%h", cyc, seg_al, dig_al, xs, xd);
      end
    end
    Load = 1'b1; Value = 16'h0000;
    step();
    Load = 1'b0;
    vectors++; if (seg_al !== 7'h7F || dig_al !== 4'hF || fd_al !== 1'b1) begin
      errors++; $display("FAIL lz_0070_d3: got seg=%h dig=%h fd=%b expected seg=7f dig=f fd=1", seg_al, dig_al, fd_al);
    end
    for (int t = 0; t < 15; t++) begin
      step();
      xs = ((t % 4) == 0) ? 7'h7F : es6[t/4];
      xd = ((t % 4) == 0) ? 4'hF  : ed6[t/4];
      vectors++; if (seg_al !== xs || dig_al !== xd) begin
        errors++; $display("FAIL lz_0000 cyc%0d: got seg=%h dig=%h expected seg=%h dig=%h", cyc, seg_al, dig_al, xs, xd);
      end
    end
    Load = 1'b1; Value = 16'h8888; Lz_Suppress = 1'b0;
    step();
    Load = 1'b0;
    vectors++; if (seg_al !== 7'h40 || dig_al !== 4'h7) begin
      errors++; $display("FAIL lz_live_off: got seg=%h dig=%h expected seg=40 dig=7", seg_al, dig_al);
    end
  endtask

  task automatic test_mask_polarity();
    logic [6:0] es_al [4];
    logic [3:0] ed_al [4];
    logic [6:0] es_ah [4];
    logic [3:0] ed_ah [4];
    logic [6:0] xs, xsh;
    logic [3:0] xd, xdh;
    es_al = '{7'h7F, 7'h00, 7'h7F, 7'h00};
    ed_al = '{4'hF, 4'hD, 4'hF, 4'h7};
    es_ah = '{7'h00, 7'h7F, 7'h00, 7'h7F};
    ed_ah = '{4'h0, 4'h2, 4'h0, 4'h8};
    Blank_Mask = 4'b0101;
    for (int t = 0; t < 16; t++) begin
      step();
      xs  = ((t % 4) == 0) ? 7'h7F : es_al[t/4];
      xd  = ((t % 4) == 0) ? 4'hF  : ed_al[t/4];
      xsh = ((t % 4) == 0) ? 7'h00 : es_ah[t/4];
      xdh = ((t % 4) == 0) ? 4'h0  : ed_ah[t/4];
      vectors++; if (seg_al !== xs || dig_al !== xd) begin
        errors++; $display("FAIL mask_al cyc%0d: got seg=%h dig=%h expected seg=%h dig=%h", cyc, seg_al, dig_al, xs, xd);
      end
      vectors++; if (seg_ah !== xsh || dig_ah !== xdh) begin
        errors++; $display("FAIL mask_ah cyc%0d: got seg=%h dig=%h expected seg=%h dig=%h", cyc, seg_ah, dig_ah, xsh, xdh);
      end
    end
    vectors++; if (fd_ah !== 1'b1) begin errors++; $display("FAIL fd_ah112: got %b expected 1", fd_ah); end
  endtask

  task automatic test_reset_discard();
    logic [6:0] xs;
    logic [3:0] xd;
    logic [3:0] ed [4];
    ed = '{4'hE, 4'hD, 4'hB, 4'h7};
    Blank_Mask = 4'b0000;
    wait_to(114);
    Load = 1'b1; Value = 16'h4321;
    step();
    Load = 1'b0;
    #2 Reset = 1'b1;
    #1;
    vectors++; if (seg_al !== 7'h7F || dig_al !== 4'hF || fd_al !== 1'b0) begin
      errors++; $display("FAIL discard_rst: got seg=%h dig=%h fd=%b expected seg=7f dig=f fd=0", seg_al, dig_al, fd_al);
    end
    @(negedge clk);
    Reset = 1'b0; cyc = 0;
    wait_to(16);
    vectors++; if (fd_al !== 1'b1) begin errors++; $display("FAIL discard_fd16: got %b expected 1", fd_al); end
    for (int t = 0; t < 16; t++) begin
      step();
      xs = ((t % 4) == 0) ? 7'h7F : 7'h40;
      xd = ((t % 4) == 0) ? 4'hF  : ed[t/4];
      vectors++; if (seg_al !== xs || dig_al !== xd) begin
        errors++; $display("FAIL discard cyc%0d: got seg=%h dig=%h expected seg=%h dig=%h", cyc, seg_al, dig_al, xs, xd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tearing();
    test_suppress();
    test_mask_polarity();
    test_reset_discard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hex_scan_display.md
HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed hex digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (>=2).
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, leading cycles of each slot with all digits off (0..REFRESH_DIV-1).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; 1 = segments and digit selects active-low, 0 = active-high.
REQ-005 SHALL have port Clk  input  1  system clock, rising edge.
REQ-006 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port Value  input  4*NUM_DIGITS  hex value to display; nibble i drives digit i, digit 0 least significant.
REQ-008 SHALL have port Load  input  1  one-cycle strobe capturing Value.
REQ-009 SHALL have port Blank_Mask  input  NUM_DIGITS  bit i=1 forces digit i dark, sampled live.
REQ-010 SHALL have port Lz_Suppress  input  1  enables leading-zero suppression, sampled live.
REQ-011 SHALL have port Seg  output  7  segments {g,f,e,d,c,b,a}, bit 6 = g, registered.
REQ-012 SHALL have port Dig_Sel  output  NUM_DIGITS  one-hot digit enable, registered.
REQ-013 SHALL have port Frame_Done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-014 SHALL run prescaler 0..REFRESH_DIV-1, wrapping to 0; terminal count is the slot tick.
REQ-015 SHALL advance digit index 0..NUM_DIGITS-1 on each tick, wrapping to 0 after NUM_DIGITS-1.
REQ-016 SHALL assert Frame_Done for exactly the cycle after the tick on which the index wraps.
REQ-017 SHALL capture Value into a pending register on Load and set a pending flag; a later Load before transfer overwrites pending.
REQ-018 SHALL copy pending into the active register and clear the flag only on the wrap tick (no mid-frame tearing).
REQ-019 SHALL, on Load coincident with the wrap tick, load Value directly into active and leave the flag clear.
REQ-020 SHALL drive Dig_Sel all-inactive while prescaler < BLANK_CYCLES, else only bit index active.
REQ-021 SHALL, with Lz_Suppress=1, dark digit i (i>0) when it and all higher active nibbles are 0; digit 0 never suppressed.
REQ-022 SHALL output all segments off for a dark digit (masked, suppressed, or blank interval), while the digit enable follows REQ-020 unless masked or suppressed, in which case the enable is also inactive.
REQ-023 SHALL encode active-low patterns (hex, bit6=g): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E; ACTIVE_LOW=0 inverts all Seg and Dig_Sel bits.
REQ-024 SHALL register Seg/Dig_Sel from current prescaler, index, active register and live masks: one-cycle latency.
REQ-025 SHALL never drive X on any output, including unreachable index values (treated as dark).

Reset
REQ-026 SHALL, on Reset high, asynchronously clear prescaler, index, pending register, pending flag and active register to 0.
REQ-027 SHALL, during reset, drive Seg all off, Dig_Sel all inactive, Frame_Done 0.
REQ-028 SHALL resume counting from prescaler 0, index 0 on the first rising Clk after Reset deasserts; reset mid-frame discards any pending value.

Verification
(Bench params: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1.)
REQ-029 SHALL check reset: Reset pulsed mid-slot asynchronously -> Seg=7F, Dig_Sel=F, Frame_Done=0 before next edge; after release digit 0 shows "0" (Seg=40, Dig_Sel=E).
REQ-030 SHALL check scan: Load Value=16'h12AF at wrap -> slots show F(0E,E), A(08,D), 2(24,B), 1(79,7); Dig_Sel=F for 1 cycle per slot; Frame_Done every 16 cycles.
REQ-031 SHALL check tearing: Load 16'h1234 then 16'h5678 mid-frame -> remainder of frame unchanged, next frame shows 5678 only.
REQ-032 SHALL check suppression: active 16'h0070, Lz_Suppress=1 -> digits 3,2 dark (Seg=7F, enable inactive), digit1=78, digit0=40; active 0000 -> only digit 0 lit with 40.
REQ-033 SHALL check masking/polarity: Blank_Mask=4'b0101 -> digits 0,2 dark; ACTIVE_LOW=0 build shows digit "8" as Seg=7F, one-hot Dig_Sel active-high.
